// File: rtl/pulse_sync_multi.sv
// Multi-channel pulse synchronizer: async level -> synchronized level, edge pulse, sticky pend flag.
// Define PULSE_SYNC_CNT_EN to add a saturating per-channel event counter (evt_cnt / cnt_clr).
module pulse_sync_multi #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     async_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    output logic [NUM_CH-1:0]     sync_out,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     pend,
    input  logic [NUM_CH-1:0]     pend_clr
`ifdef PULSE_SYNC_CNT_EN
    ,
    input  logic [NUM_CH-1:0]     cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt
`endif
);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0] r_hist;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] w_modeRise;
    logic [NUM_CH-1:0] w_modeFall;
    logic [NUM_CH-1:0] w_pulse;

    // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_pend <= '0;
        end else begin
            r_hist <= sync_out;
            r_pend <= (r_pend & ~pend_clr) | w_pulse;
        end
    end

    always_comb begin
        w_modeRise = '0;
        w_modeFall = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_modeRise[i] = edge_mode[2*i];
            w_modeFall[i] = edge_mode[2*i+1];
        end
    end

    // Edges come from flop outputs only, so the mode mask is the only live input on this path.
    assign w_rise    = sync_out & ~r_hist;
    assign w_fall    = ~sync_out & r_hist;
    assign w_pulse   = (w_rise & w_modeRise) | (w_fall & w_modeFall);
    assign pulse_out = w_pulse;
    assign pend      = r_pend;

`ifdef PULSE_SYNC_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;

    // A clear in the same cycle as a pulse leaves that pulse counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clr[i]) begin
                    r_cnt[i] <= CNT_W'(w_pulse[i]);
                end else if (w_pulse[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign evt_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Self-checking bench for pulse_sync_multi: directed steps plus a pulse scoreboard on an 8-channel
// instance (SYNC_STAGES=2, CNT_W=2) and reset checks on a 4-channel SYNC_STAGES=3 instance.
module tb_pulse_sync_multi;

    typedef struct packed {
        int unsigned cyc;
        logic [7:0]  mask;
    } evt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned edgeNo = 0;
    always @(posedge clk) edgeNo <= edgeNo + 1;

    logic        rst2;
    logic [7:0]  async2;
    logic [15:0] mode2;
    logic [7:0]  clr2;
    logic [7:0]  sync2;
    logic [7:0]  pulse2;
    logic [7:0]  pend2;
    logic        rst3;
    logic [3:0]  async3;
    logic [7:0]  mode3;
    logic [3:0]  clr3;
    logic [3:0]  sync3;
    logic [3:0]  pulse3;
    logic [3:0]  pend3;
`ifdef PULSE_SYNC_CNT_EN
    logic [7:0]  cntClr2;
    logic [15:0] evtCnt2;
    logic [3:0]  cntClr3;
    logic [31:0] evtCnt3;
`endif

    pulse_sync_multi #(.NUM_CH(8), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .async_in(async2), .edge_mode(mode2),
        .sync_out(sync2), .pulse_out(pulse2), .pend(pend2), .pend_clr(clr2)
`ifdef PULSE_SYNC_CNT_EN
        , .cnt_clr(cntClr2), .evt_cnt(evtCnt2)
`endif
    );

    pulse_sync_multi #(.NUM_CH(4), .SYNC_STAGES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst3), .async_in(async3), .edge_mode(mode3),
        .sync_out(sync3), .pulse_out(pulse3), .pend(pend3), .pend_clr(clr3)
`ifdef PULSE_SYNC_CNT_EN
        , .cnt_clr(cntClr3), .evt_cnt(evtCnt3)
`endif
    );

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;
    evt_t expQ[$];
    evt_t obsQ[$];
    int expCnt[8];
    int obsCnt[8];

    // Monitor: every pulse seen on the 8-channel instance is logged with its edge number.
    always @(negedge clk) begin
        if (pulse2 != 8'h00) begin
            obsQ.push_back(evt_t'{cyc: edgeNo, mask: pulse2});
        end
        for (int c = 0; c < 8; c++) begin
            if (pulse2[c] === 1'b1) obsCnt[c] <= obsCnt[c] + 1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new level on the 8-channel instance; the expected pulse lands two edges later.
    task automatic applyStimulus(input logic [7:0] nv);
        logic [7:0] r;
        logic [7:0] f;
        logic [7:0] mR;
        logic [7:0] mF;
        logic [7:0] m;
        r = nv & ~async2;
        f = ~nv & async2;
        for (int c = 0; c < 8; c++) begin
            mR[c] = mode2[2*c];
            mF[c] = mode2[2*c+1];
        end
        m = (r & mR) | (f & mF);
        if (m != 8'h00) expQ.push_back(evt_t'{cyc: edgeNo + 2, mask: m});
        for (int c = 0; c < 8; c++) begin
            if (m[c]) expCnt[c]++;
        end
        async2 = nv;
    endtask

    task automatic sbCheck(input string tag);
        evt_t e;
        evt_t o;
        checkOutput({tag, "_evtcount"}, 64'(obsQ.size()), 64'(expQ.size()));
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkOutput({tag, "_evt"}, 64'(o), 64'(e));
        end
        while (expQ.size() > 0) e = expQ.pop_front();
        while (obsQ.size() > 0) o = obsQ.pop_front();
    endtask

    initial begin
        int base;
        logic [3:0] seen;
        rst2 = 1'b1; async2 = 8'h00; mode2 = 16'h0000; clr2 = 8'h00;
        rst3 = 1'b1; async3 = 4'hF;  mode3 = 8'hFF;    clr3 = 4'h0;
`ifdef PULSE_SYNC_CNT_EN
        cntClr2 = 8'h00; cntClr3 = 4'h0;
`endif
        $display("[TB] start");

        // Channels held high through reset pulse together three edges after release.
        step(3);
        checkOutput("rst3_sync", sync3, 4'h0);
        checkOutput("rst3_pulse", pulse3, 4'h0);
        checkOutput("rst3_pend", pend3, 4'h0);
        rst3 = 1'b0;
        step();
        checkOutput("post_rst3_sync", sync3, 4'h0);
        checkOutput("post_rst3_pulse", pulse3, 4'h0);
        checkOutput("post_rst3_pend", pend3, 4'h0);
`ifdef PULSE_SYNC_CNT_EN
        checkOutput("post_rst3_cnt", evtCnt3, 32'h0);
`endif
        step();
        checkOutput("rst3_rel_plus2_pulse", pulse3, 4'h0);
        step();
        checkOutput("rst3_rel_plus3_pulse", pulse3, 4'hF);
        checkOutput("rst3_rel_plus3_sync", sync3, 4'hF);
        step();
        checkOutput("rst3_rel_plus4_pulse", pulse3, 4'h0);
        checkOutput("rst3_rel_plus4_pend", pend3, 4'hF);

        // Reset in the middle of the sync chain swallows the edge.
        mode3 = 8'h55;
        async3 = 4'h0;
        step(5);
        clr3 = 4'hF;
        step();
        clr3 = 4'h0;
        step();
        checkOutput("abort_pre_pend", pend3, 4'h0);
        async3 = 4'hF;
        step();
        rst3 = 1'b1;
        async3 = 4'h0;
        step(2);
        rst3 = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | pulse3;
        end
        checkOutput("abort_no_pulse", seen, 4'h0);
        checkOutput("abort_pend", pend3, 4'h0);

        // 8-channel instance reset state.
        checkOutput("rst2_sync", sync2, 8'h00);
        checkOutput("rst2_pulse", pulse2, 8'h00);
        checkOutput("rst2_pend", pend2, 8'h00);
        rst2 = 1'b0;
        step();
        checkOutput("post_rst2_sync", sync2, 8'h00);
        checkOutput("post_rst2_pend", pend2, 8'h00);
`ifdef PULSE_SYNC_CNT_EN
        checkOutput("post_rst2_cnt", evtCnt2, 16'h0000);
`endif
        step(2);

        // ch0 rise mode: sync from +2 edges, single pulse, pend one edge later.
        mode2 = 16'h0001;
        step();
        applyStimulus(8'h01);
        step();
        checkOutput("ch0_e1_sync", sync2[0], 1'b0);
        checkOutput("ch0_e1_pulse", pulse2[0], 1'b0);
        step();
        checkOutput("ch0_e2_sync", sync2[0], 1'b1);
        checkOutput("ch0_e2_pulse", pulse2, 8'h01);
        checkOutput("ch0_e2_pend", pend2[0], 1'b0);
        step();
        checkOutput("ch0_e3_pulse", pulse2[0], 1'b0);
        checkOutput("ch0_e3_pend", pend2[0], 1'b1);
        step(3);
        checkOutput("ch0_held_no_repulse", pulse2, 8'h00);
`ifdef PULSE_SYNC_CNT_EN
        checkOutput("ch0_cnt", evtCnt2[1:0], 2'd1);
`endif
        sbCheck("ch0_rise");

        // ch1 toggled 1,0,1 under both-edge mode then under fall-only mode.
        mode2 = 16'h000C;
        step();
        base = obsCnt[1];
        applyStimulus(async2 | 8'h02);
        step(10);
        applyStimulus(async2 & ~8'h02);
        step(10);
        applyStimulus(async2 | 8'h02);
        step(10);
        checkOutput("ch1_both_pulses", 64'(obsCnt[1] - base), 64'd3);
        mode2 = 16'h0000;
        applyStimulus(async2 & ~8'h02);
        step(4);
        mode2 = 16'h0008;
        step();
        base = obsCnt[1];
        applyStimulus(async2 | 8'h02);
        step(10);
        applyStimulus(async2 & ~8'h02);
        step(10);
        applyStimulus(async2 | 8'h02);
        step(10);
        checkOutput("ch1_fall_pulses", 64'(obsCnt[1] - base), 64'd1);
        sbCheck("ch1_toggle");

        // pend_clr coinciding with the pulse loses to the set; alone it clears.
        mode2 = 16'h0010;
        step();
        applyStimulus(async2 | 8'h04);
        step();
        checkOutput("ch2_pre_pend", pend2[2], 1'b0);
        step();
        checkOutput("ch2_pulse", pulse2[2], 1'b1);
        clr2 = 8'h04;
        step();
        checkOutput("ch2_set_wins", pend2[2], 1'b1);
        step();
        checkOutput("ch2_cleared", pend2[2], 1'b0);
        clr2 = 8'h00;
        step(2);
        sbCheck("ch2_pend");

`ifdef PULSE_SYNC_CNT_EN
        // ch3 counter saturates at 3 after five rises; clear with a pulse leaves 1.
        mode2 = 16'h0040;
        step();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(async2 | 8'h08);
            step(3);
            applyStimulus(async2 & ~8'h08);
            step(3);
            if (i == 1) checkOutput("ch3_cnt_two", evtCnt2[7:6], 2'd2);
        end
        checkOutput("ch3_cnt_sat", evtCnt2[7:6], 2'd3);
        applyStimulus(async2 | 8'h08);
        step(2);
        checkOutput("ch3_clr_pulse", pulse2[3], 1'b1);
        cntClr2 = 8'h08;
        step();
        cntClr2 = 8'h00;
        checkOutput("ch3_cnt_clr_with_pulse", evtCnt2[7:6], 2'd1);
        step(2);
        sbCheck("ch3_cnt");
`endif

        // Random toggling on all channels, both edges enabled.
        mode2 = 16'hFFFF;
        step(3);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(async2 ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255))));
            step();
        end
        step(4);
        sbCheck("random");
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("random_count_ch%0d", c), 64'(obsCnt[c]), 64'(expCnt[c]));
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/pulse_sync_multi.md
PULSE_SYNC_MULTI -- requirements
Module: pulse_sync_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent channels, legal 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, legal 2..4.
REQ-003 SHALL have parameter CNT_W, default 8: event counter width, legal 2..16.
REQ-004 SHALL have port clk, input, 1: sole clock; one clock, all flops on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port async_in, input, NUM_CH: asynchronous level per channel.
REQ-007 SHALL have port edge_mode, input, 2*NUM_CH: per channel, bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port sync_out, output, NUM_CH: synchronized level, last sync stage.
REQ-009 SHALL have port pulse_out, output, NUM_CH: one-cycle event pulse per channel.
REQ-010 SHALL have port pend, output, NUM_CH: sticky event flag per channel.
REQ-011 SHALL have port pend_clr, input, NUM_CH: per-channel clear of pend.
REQ-012 SHALL have ports evt_cnt, output, NUM_CH*CNT_W, and cnt_clr, input, NUM_CH, only when PULSE_SYNC_CNT_EN is defined.

Function
REQ-013 SHALL pass each async_in bit through SYNC_STAGES flops; sync_out = last stage; no logic between stages.
REQ-014 SHALL hold a history flop per channel = sync_out of the previous cycle.
REQ-015 SHALL define rise = sync_out & ~hist, fall = ~sync_out & hist, computed from flop outputs only.
REQ-016 SHALL drive pulse_out[i] = (rise & mode bit0) | (fall & mode bit1), with the mode sampled in the same cycle; mode 00 gives no pulses.
REQ-017 SHALL give latency: async_in stable before clk edge k -> sync_out changes after edge k+SYNC_STAGES-1; pulse_out is high for exactly that one cycle.
REQ-018 SHALL NOT re-pulse while the level is held; an input toggle shorter than one clk period MAY be lost. Each toggle seen by the sync chain yields at most one pulse.
REQ-019 SHALL set pend[i] on the edge after pulse_out[i]; pend holds until pend_clr[i]; pend_clr and pulse in the same cycle -> pend stays 1 (set wins).
REQ-020 SHALL process channels fully independently; simultaneous events on all channels SHALL all be reported in the same cycle.
REQ-021 SHALL ignore a change of edge_mode for past edges; only the current cycle's rise/fall is masked.

Reset
REQ-022 SHALL clear all sync stages, history, and pend, plus counters when present, to 0 on any clk edge with rst=1.
REQ-023 SHALL hold pulse_out=0, pend=0, sync_out=0 and evt_cnt=0 during reset and in the first cycle after it.
REQ-024 SHALL, for a channel held high through reset, produce one rise pulse SYNC_STAGES cycles after rst deasserts.
REQ-025 SHALL abort any in-flight edge when rst asserts mid-operation; no pulse is emitted for it.

Configuration
REQ-026 SHALL, with PULSE_SYNC_CNT_EN defined, keep a CNT_W-bit counter per channel that increments on each pulse_out and saturates at 2^CNT_W-1.
REQ-027 SHALL, with PULSE_SYNC_CNT_EN defined, zero a counter on cnt_clr; cnt_clr together with a pulse in the same cycle -> counter = 1.
REQ-028 SHALL, without PULSE_SYNC_CNT_EN, omit evt_cnt, cnt_clr and all counter flops; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover: SYNC_STAGES=2, mode 01, ch0 rises before edge 5 -> sync_out[0]=1 from edge 6, pulse_out[0]=1 for one cycle only, pend[0]=1 from edge 7.
REQ-030 SHALL cover: mode 11, ch1 toggles 1,0,1 every 10 cycles -> exactly 3 pulses; mode 10 with the same stimulus -> exactly 1 pulse.
REQ-031 SHALL cover: pend_clr[2] asserted in the same cycle as pulse_out[2] -> pend[2]=1; pend_clr alone next cycle -> pend[2]=0.
REQ-032 SHALL cover: async_in=all ones held through reset, SYNC_STAGES=3 -> all channels pulse together 3 cycles after rst deasserts; rst asserted mid-chain -> no pulse.
REQ-033 SHALL cover, with PULSE_SYNC_CNT_EN and CNT_W=2: 5 rise pulses -> evt_cnt=3 (saturated); cnt_clr with a pulse -> evt_cnt=1.
REQ-034 SHALL cover: NUM_CH=8, random async_in with mode 11 for 10k cycles -> pulse count per channel equals the model's toggle count on sync_out.
